// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences lw/sw/R-type/beq/addi/j and
// drives every datapath enable, mux select and the 3-bit ALU code.
//
// Ports:
//   clk, rst_n     rising-edge clock, async active-low reset
//   op, funct      instruction fields from the instruction register
//   zero           ALU zero flag (used in BEQEX only)
//   pcEn           PC load = pcWrite | (branch & zero)
//   iorD           memory address: 0 = PC, 1 = ALUOut
//   memWrite       data memory write strobe
//   irWrite        instruction register load
//   regDst         write address: 0 = rt, 1 = rd
//   memtoReg       write data: 0 = ALUOut, 1 = memory data
//   regWrite       register file write enable
//   aluSrcA        ALU A: 0 = PC, 1 = register A
//   aluSrcB        ALU B: 00 B, 01 4, 10 imm, 11 imm<<2
//   pcSrc          next PC: 00 ALU, 01 ALUOut, 10 jump target
//   aluControl     010 add, 110 sub, 000 and, 001 or, 111 slt
//   state          current state (debug)
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcEn,
    output logic       iorD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memtoReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic [2:0] aluControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_memto_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; codes 12-15 fall into the default and recover.
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYP:      w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // Moore output decode.
    always_comb begin
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_iord      = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_dst   = 1'b0;
        w_memto_reg = 1'b0;
        w_reg_write = 1'b0;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'b00;
        w_pc_src    = 2'b00;
        w_alu_op    = 2'b00;
        case (r_state)
            FETCH: begin
                w_alu_src_b = 2'b01;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            DECODE: begin
                w_alu_src_b = 2'b11;
            end
            MEMADR, ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            MEMRD: begin
                w_iord = 1'b1;
            end
            MEMWB: begin
                w_memto_reg = 1'b1;
                w_reg_write = 1'b1;
            end
            MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            RTYPEEX: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            RTYPEWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            BEQEX: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            ADDIWB: begin
                w_reg_write = 1'b1;
            end
            JEX: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                w_alu_op = 2'b00;
            end
        endcase
    end

    // ALU decoder; unknown funct yields AND.
    always_comb begin
        w_alu_ctl = 3'b000;
        case (w_alu_op)
            2'b00: w_alu_ctl = 3'b010;
            2'b01: w_alu_ctl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: w_alu_ctl = 3'b010;
                    6'b100010: w_alu_ctl = 3'b110;
                    6'b100100: w_alu_ctl = 3'b000;
                    6'b100101: w_alu_ctl = 3'b001;
                    6'b101010: w_alu_ctl = 3'b111;
                    default:   w_alu_ctl = 3'b000;
                endcase
            end
            default: w_alu_ctl = 3'b000;
        endcase
    end

    // Strobes are gated by rst_n so nothing writes while reset is held,
    // even in the instant before the async clear propagates.
    assign pcEn       = rst_n & (w_pc_write | (w_branch & zero));
    assign irWrite    = rst_n & w_ir_write;
    assign memWrite   = rst_n & w_mem_write;
    assign regWrite   = rst_n & w_reg_write;
    assign iorD       = w_iord;
    assign regDst     = w_reg_dst;
    assign memtoReg   = w_memto_reg;
    assign aluSrcA    = w_alu_src_a;
    assign aluSrcB    = w_alu_src_b;
    assign pcSrc      = w_pc_src;
    assign aluControl = w_alu_ctl;
    assign state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: directed instructions plus
// random ones, checked against a per-instruction reference model.
module tb_mips_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcEn;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [2:0] aluControl;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcEn       (pcEn),
        .iorD       (iorD),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regDst     (regDst),
        .memtoReg   (memtoReg),
        .regWrite   (regWrite),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .pcSrc      (pcSrc),
        .aluControl (aluControl),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {state, pcEn, iorD, memWrite, irWrite, regDst,
    // memtoReg, regWrite, aluSrcA, aluSrcB, pcSrc, aluControl}
    function automatic logic [18:0] observed();
        return {state, pcEn, iorD, memWrite, irWrite, regDst, memtoReg,
                regWrite, aluSrcA, aluSrcB, pcSrc, aluControl};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs,
                         input logic [18:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected state walk of one instruction, named by step.
    task automatic exp_seq(input logic [5:0] o, output int s[5],
                           output int n);
        s = '{0, 1, 0, 0, 0};
        case (o)
            6'b100011: begin s[2] = 2; s[3] = 3; s[4] = 4; n = 5; end
            6'b101011: begin s[2] = 2; s[3] = 5; n = 4; end
            6'b000000: begin s[2] = 6; s[3] = 7; n = 4; end
            6'b000100: begin s[2] = 8; n = 3; end
            6'b001000: begin s[2] = 9; s[3] = 10; n = 4; end
            6'b000010: begin s[2] = 11; n = 3; end
            default:   n = 2;
        endcase
    endtask

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // What the datapath should see in a given step.
    function automatic logic [18:0] expect_out(input int s,
        input logic [5:0] f, input logic z);
        logic pe, io, mw, iw, rd, mr, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        pe = (s == 0) || (s == 11) || (s == 8 && z);
        io = (s == 3) || (s == 5);
        mw = (s == 5);
        iw = (s == 0);
        rd = (s == 7);
        mr = (s == 4);
        rw = (s == 4) || (s == 7) || (s == 10);
        sa = (s == 2) || (s == 9) || (s == 6) || (s == 8);
        sb = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 :
             (s == 2 || s == 9) ? 2'b10 : 2'b00;
        ps = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
        ac = (s == 6) ? rtype_alu(f) : (s == 8) ? 3'b110 : 3'b010;
        return {4'(s), pe, io, mw, iw, rd, mr, rw, sa, sb, ps, ac};
    endfunction

    // Runs one instruction from FETCH; zm 0/1 fixes zero, 2 randomizes.
    // Starts and ends at a negedge.
    task automatic run_instr(input string nm, input logic [5:0] o,
                             input logic [5:0] f, input int zm);
        int s[5];
        int n;
        exp_seq(o, s, n);
        op = o;
        funct = f;
        for (int i = 0; i < n; i++) begin
            zero = (zm == 2) ? 1'($urandom) : 1'(zm);
            #1;
            check($sformatf("%s step%0d", nm, i), observed(),
                  expect_out(s[i], f, zero));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                            6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010};

    initial begin
        logic [5:0] ro;
        logic [5:0] rf;
        logic [18:0] rst_exp;
        rst_n = 1'b0;
        op = 6'b0;
        funct = 6'b0;
        zero = 1'b0;
        // FETCH values with strobes forced low, aluControl add.
        rst_exp = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 2'b01, 2'b00, 3'b010};
        #1;
        check("reset hold", observed(), rst_exp);
        @(posedge clk);
        @(negedge clk);
        check("reset across edge", observed(), rst_exp);
        rst_n = 1'b1;

        run_instr("lw", 6'b100011, 6'b000000, 0);
        run_instr("slt", 6'b000000, 6'b101010, 0);
        run_instr("and", 6'b000000, 6'b100100, 1);
        run_instr("beq z1", 6'b000100, 6'b000000, 1);
        run_instr("beq z0", 6'b000100, 6'b000000, 0);
        run_instr("sw", 6'b101011, 6'b000000, 1);
        run_instr("j", 6'b000010, 6'b000000, 0);
        run_instr("illegal", 6'b111111, 6'b000000, 1);
        run_instr("addi", 6'b001000, 6'b000000, 1);
        run_instr("badfunct", 6'b000000, 6'b111111, 0);

        // Abort an R-type in RTYPEWB with a mid-cycle reset pulse.
        op = 6'b000000;
        funct = 6'b100000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("pre-abort rtypewb", observed(),
              expect_out(7, funct, zero));
        #1;
        rst_n = 1'b0;
        #1;
        check("async abort", observed(), rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("after abort", 6'b000000, 6'b100010, 2);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                ro = 6'($urandom);
                while (ro inside {ops}) ro = 6'($urandom);
            end else begin
                ro = ops[$urandom_range(0, 5)];
            end
            if ($urandom_range(0, 5) == 0) rf = 6'($urandom);
            else rf = fns[$urandom_range(0, 4)];
            run_instr($sformatf("rnd%0d", k), ro, rf, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
